// File: rtl/sram_responder_pkg.sv
// Shared types and constants for the SRAM responder.
// Access-kind decode is shared by the responder and its statistics block.
package sram_responder_pkg;

    localparam int SRAM_DW = 32;
    localparam int SRAM_BW = 4;
    localparam int SRAM_AW_DEFAULT = 12;
    localparam logic [31:0] SRAM_BASE_DEFAULT = 32'hBFC0_0000;

    typedef enum logic [1:0] {
        ACC_IDLE,
        ACC_READ,
        ACC_WRITE,
        ACC_ERR
    } acc_t;

    function automatic logic [SRAM_DW-1:0] lane_merge(
        input logic [SRAM_DW-1:0] old,
        input logic [SRAM_DW-1:0] wdata,
        input logic [SRAM_BW-1:0] wen
    );
        logic [SRAM_DW-1:0] res;
        res = old;
        for (int i = 0; i < SRAM_BW; i++) begin
            if (wen[i]) begin
                res[8*i +: 8] = wdata[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sram_resp_stat.sv
// Saturating read / write / error counters for the SRAM responder.
// Only instantiated when SRAM_RESP_STAT_EN is defined.
module sram_resp_stat
    import sram_responder_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  acc_t        kind,
    output logic [31:0] rd_cnt,
    output logic [31:0] wr_cnt,
    output logic [31:0] err_cnt
);

    logic [31:0] rd_q;
    logic [31:0] wr_q;
    logic [31:0] err_q;

    // Count each access kind, holding at all-ones instead of wrapping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            err_q <= '0;
        end else begin
            if (kind == ACC_READ && rd_q != '1) begin
                rd_q <= rd_q + 32'd1;
            end
            if (kind == ACC_WRITE && wr_q != '1) begin
                wr_q <= wr_q + 32'd1;
            end
            if (kind == ACC_ERR && err_q != '1) begin
                err_q <= err_q + 32'd1;
            end
        end
    end

    assign rd_cnt  = rd_q;
    assign wr_cnt  = wr_q;
    assign err_cnt = err_q;

endmodule

// File: rtl/sram_responder.sv
// Byte-lane-writable single-port SRAM responder with registered read data,
// window decode, error pulse and backdoor preload. Stats: SRAM_RESP_STAT_EN.
module sram_responder
    import sram_responder_pkg::*;
#(
    parameter int          AW        = SRAM_AW_DEFAULT,
    parameter logic [31:0] BASE_ADDR = SRAM_BASE_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sram_en,
    input  logic [SRAM_BW-1:0] sram_wen,
    input  logic [31:0]        sram_addr,
    input  logic [SRAM_DW-1:0] sram_wdata,
    output logic [SRAM_DW-1:0] sram_rdata,
    output logic               sram_err,
    input  logic               ld_en,
    input  logic [AW-1:0]      ld_addr,
    input  logic [SRAM_DW-1:0] ld_data,
    output logic [31:0]        stat_rd_cnt,
    output logic [31:0]        stat_wr_cnt,
    output logic [31:0]        stat_err_cnt
);

    logic [SRAM_DW-1:0] mem [2**AW];
    logic [AW-1:0]      idx;
    logic               in_range;
    logic               ld_hit;
    acc_t               kind;
    logic               unused_addr;

    assign idx         = sram_addr[AW+1:2];
    assign in_range    = sram_addr[31:AW+2] == BASE_ADDR[31:AW+2];
    assign ld_hit      = ld_en && (ld_addr == idx);
    assign unused_addr = ^sram_addr[1:0];

    // Classify this cycle's request
    always_comb begin
        kind = ACC_IDLE;
        if (sram_en) begin
            if (!in_range) begin
                kind = ACC_ERR;
            end else if (sram_wen == '0) begin
                kind = ACC_READ;
            end else begin
                kind = ACC_WRITE;
            end
        end
    end

    // Memory array: port write first, backdoor load overrides on a clash
    always_ff @(posedge clk) begin
        if (rst) begin
            if (kind == ACC_WRITE && !ld_hit) begin
                mem[idx] <= lane_merge(mem[idx], sram_wdata, sram_wen);
            end
            if (ld_en) begin
                mem[ld_addr] <= ld_data;
            end
        end
    end

    // Registered read data and one-cycle error pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sram_rdata <= '0;
            sram_err   <= 1'b0;
        end else begin
            sram_err <= (kind == ACC_ERR);
            if (kind == ACC_READ) begin
                sram_rdata <= mem[idx];
            end else if (kind == ACC_ERR) begin
                sram_rdata <= '0;
            end
        end
    end

`ifdef SRAM_RESP_STAT_EN
    sram_resp_stat u_stat (
        .clk     (clk),
        .rst     (rst),
        .kind    (kind),
        .rd_cnt  (stat_rd_cnt),
        .wr_cnt  (stat_wr_cnt),
        .err_cnt (stat_err_cnt)
    );
`else
    assign stat_rd_cnt  = '0;
    assign stat_wr_cnt  = '0;
    assign stat_err_cnt = '0;
`endif

endmodule

// File: tb/tb_sram_responder.sv
// Randomized bench for sram_responder against an array-based memory model.
// Statistics checks are active when SRAM_RESP_STAT_EN is defined.
module tb_sram_responder;

    localparam int          AW    = 12;
    localparam int          DEPTH = 1 << AW;
    localparam logic [31:0] BASE  = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sram_en = 1'b0;
    logic [3:0]  sram_wen = '0;
    logic [31:0] sram_addr = '0;
    logic [31:0] sram_wdata = '0;
    logic [31:0] sram_rdata;
    logic        sram_err;
    logic        ld_en = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [31:0] ld_data = '0;
    logic [31:0] stat_rd_cnt;
    logic [31:0] stat_wr_cnt;
    logic [31:0] stat_err_cnt;

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] mdl [DEPTH];
    logic [31:0] exp_rd = '0;
    logic        exp_err = 1'b0;
    int          c_rd = 0;
    int          c_wr = 0;
    int          c_er = 0;

    always #5 clk = ~clk;

    sram_responder #(.AW(AW), .BASE_ADDR(BASE)) dut (
        .clk          (clk),
        .rst          (rst),
        .sram_en      (sram_en),
        .sram_wen     (sram_wen),
        .sram_addr    (sram_addr),
        .sram_wdata   (sram_wdata),
        .sram_rdata   (sram_rdata),
        .sram_err     (sram_err),
        .ld_en        (ld_en),
        .ld_addr      (ld_addr),
        .ld_data      (ld_data),
        .stat_rd_cnt  (stat_rd_cnt),
        .stat_wr_cnt  (stat_wr_cnt),
        .stat_err_cnt (stat_err_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock of traffic; model updated from the rules, then one edge
    task automatic op(input logic en, input logic [3:0] wen,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic ld, input logic [AW-1:0] la,
                      input logic [31:0] lv);
        logic          in_rng;
        logic [AW-1:0] idx;
        sram_en    = en;
        sram_wen   = wen;
        sram_addr  = addr;
        sram_wdata = wd;
        ld_en      = ld;
        ld_addr    = la;
        ld_data    = lv;
        in_rng  = (addr / (4 * DEPTH)) == (BASE / (4 * DEPTH));
        idx     = AW'((addr / 4) % DEPTH);
        exp_err = 1'b0;
        if (en) begin
            if (!in_rng) begin
                exp_rd  = '0;
                exp_err = 1'b1;
                c_er++;
            end else if (wen == 4'd0) begin
                exp_rd = mdl[idx];
                c_rd++;
            end else begin
                c_wr++;
                if (!(ld && la == idx)) begin
                    for (int i = 0; i < 4; i++) begin
                        if (wen[i]) mdl[idx][8*i +: 8] = wd[8*i +: 8];
                    end
                end
            end
        end
        if (ld) mdl[la] = lv;
        @(posedge clk);
        #1;
        sram_en  = 1'b0;
        sram_wen = '0;
        ld_en    = 1'b0;
    endtask

    task automatic opc(input string tag, input logic en,
                       input logic [3:0] wen, input logic [31:0] addr,
                       input logic [31:0] wd, input logic ld,
                       input logic [AW-1:0] la, input logic [31:0] lv);
        op(en, wen, addr, wd, ld, la, lv);
        check({tag, "_rdata"}, sram_rdata, exp_rd);
        check({tag, "_err"}, {31'd0, sram_err}, {31'd0, exp_err});
    endtask

    function automatic logic [31:0] waddr(input int i);
        return BASE + 32'(i) * 4;
    endfunction

    initial begin
        logic [31:0] a;
        logic [AW-1:0] li;
        int r;

        #12;
        check("reset_rdata", sram_rdata, 32'd0);
        check("reset_err", {31'd0, sram_err}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < DEPTH; i++) begin
            op(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, AW'(i), $urandom());
        end

        op(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, AW'(5), 32'h1234_5678);
        opc("latency", 1'b1, 4'd0, BASE + 32'h14, 32'd0, 1'b0, '0, '0);
        check("latency_val", sram_rdata, 32'h1234_5678);

        op(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, AW'(0), 32'hAABB_CCDD);
        opc("lane_wr", 1'b1, 4'b0101, BASE, 32'h1122_3344, 1'b0, '0, '0);
        opc("lane_rd", 1'b1, 4'd0, BASE, 32'd0, 1'b0, '0, '0);
        check("lane_val", sram_rdata, 32'hAA22_CC44);

        opc("oor_rd", 1'b1, 4'd0, BASE + 4 * DEPTH, 32'd0, 1'b0, '0, '0);
        opc("oor_idle", 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, '0, '0);
        opc("oor_wr", 1'b1, 4'hF, BASE + 4 * DEPTH, '1, 1'b0, '0, '0);
        opc("oor_wr_rd", 1'b1, 4'd0, BASE, 32'd0, 1'b0, '0, '0);
        check("oor_wr_val", sram_rdata, 32'hAA22_CC44);

        opc("coll", 1'b1, 4'hF, waddr(3), 32'd0, 1'b1, AW'(3), 32'hDEAD_BEEF);
        opc("coll_rd", 1'b1, 4'd0, waddr(3), 32'd0, 1'b0, '0, '0);
        check("coll_val", sram_rdata, 32'hDEAD_BEEF);

        for (int n = 0; n < 2000; n++) begin
            r = int'($urandom_range(0, 7));
            li = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 15))
                                             : AW'($urandom());
            if (r == 0) begin
                a = $urandom();
                if ((a / (4 * DEPTH)) == (BASE / (4 * DEPTH))) a[31] = ~a[31];
            end else begin
                a = waddr(int'(li)) | 32'($urandom_range(0, 3));
            end
            opc("rand", $urandom_range(0, 5) != 0,
                (r < 4) ? 4'd0 : 4'($urandom()), a, $urandom(),
                $urandom_range(0, 3) == 0,
                ($urandom_range(0, 1) == 0) ? li : AW'($urandom()),
                $urandom());
        end
`ifdef SRAM_RESP_STAT_EN
        check("rand_stat_rd", stat_rd_cnt, 32'(c_rd));
        check("rand_stat_wr", stat_wr_cnt, 32'(c_wr));
        check("rand_stat_err", stat_err_cnt, 32'(c_er));
`endif

        opc("mid_rd0", 1'b1, 4'd0, waddr(5), 32'd0, 1'b0, '0, '0);
        opc("mid_rd1", 1'b1, 4'd0, waddr(7), 32'd0, 1'b0, '0, '0);
        sram_en   = 1'b1;
        sram_addr = waddr(9);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_rdata", sram_rdata, 32'd0);
        check("mid_rst_err", {31'd0, sram_err}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("mid_hold_rdata", sram_rdata, 32'd0);
        sram_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        exp_rd = '0;
        c_rd = 0;
        c_wr = 0;
        c_er = 0;
        opc("post_rst5", 1'b1, 4'd0, waddr(5), 32'd0, 1'b0, '0, '0);
        opc("post_rst7", 1'b1, 4'd0, waddr(7), 32'd0, 1'b0, '0, '0);

`ifdef SRAM_RESP_STAT_EN
        opc("st_wr", 1'b1, 4'h3, waddr(11), $urandom(), 1'b0, '0, '0);
        opc("st_oor", 1'b1, 4'd0, 32'h0000_0010, 32'd0, 1'b0, '0, '0);
        opc("st_wr2", 1'b1, 4'hF, waddr(12), $urandom(), 1'b0, '0, '0);
        opc("st_rd", 1'b1, 4'd0, waddr(11), 32'd0, 1'b0, '0, '0);
        check("stat_rd", stat_rd_cnt, 32'd3);
        check("stat_wr", stat_wr_cnt, 32'd2);
        check("stat_err", stat_err_cnt, 32'd1);
        force dut.u_stat.rd_q = 32'hFFFF_FFFF;
        #1;
        release dut.u_stat.rd_q;
        opc("st_sat", 1'b1, 4'd0, waddr(12), 32'd0, 1'b0, '0, '0);
        check("stat_rd_sat", stat_rd_cnt, 32'hFFFF_FFFF);
`else
        check("stat_rd_off", stat_rd_cnt, 32'd0);
        check("stat_wr_off", stat_wr_cnt, 32'd0);
        check("stat_err_off", stat_err_cnt, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
